// File: rtl/mcp3008_pkg.sv
// Shared types and constants for the MCP3008 serial front-end.
// Imported by the acquisition FSM and its testbench.
package mcp3008_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SMP,
    READ,
    GAP,
    DONE
  } state_t;

  localparam int CMD_BITS  = 5;
  localparam int SMP_BITS  = 2;
  localparam int DATA_BITS = 10;
  localparam int NUM_CH    = 3;
  localparam int RESULT_W  = 32;
  localparam int PACK_W    = NUM_CH * DATA_BITS;

endpackage

// File: rtl/mcp3008_spi_interface_sample_edge_sync.sv
// Two-flop synchronizer for the async sample request,
// followed by a single-cycle rising-edge pulse.
module sample_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[0], async_in};
      prev <= sync[1];
    end
  end

  assign pulse = sync[1] & ~prev;

endmodule

// File: rtl/mcp3008_spi_interface.sv
// MCP3008 acquisition round: converts channels 0..2 and
// packs the three 10-bit results into one 32-bit word.
module mcp3008_spi_interface
  import mcp3008_pkg::*;
#(
  parameter int GAP_CYCLES   = 2,
  parameter bit SINGLE_ENDED = 1'b1
) (
  input  logic                dclk,
  input  logic                rst_n,
  input  logic                sample,
  input  logic                dout,
  output logic                din,
  output logic                cs_n,
  output logic                busy,
  output logic [RESULT_W-1:0] dout_reg
);

  localparam int MAXC = (GAP_CYCLES > DATA_BITS) ?
                        GAP_CYCLES : DATA_BITS;
  localparam int CW   = $clog2(MAXC + 1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [2:0]             ch;
  logic [CMD_BITS-1:0]    cmd_sr;
  logic [DATA_BITS-2:0]   sh;
  logic [PACK_W-1:0]      res;
  logic                   start;

  sample_edge_sync u_sync (
    .clk      (dclk),
    .rst_n    (rst_n),
    .async_in (sample),
    .pulse    (start)
  );

  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ch       <= '0;
      cmd_sr   <= '0;
      sh       <= '0;
      res      <= '0;
      busy     <= 1'b0;
      dout_reg <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= CMD;
            cnt    <= '0;
            ch     <= '0;
            busy   <= 1'b1;
            cmd_sr <= {1'b1, SINGLE_ENDED, 3'd0};
          end
        end
        CMD: begin
          cmd_sr <= {cmd_sr[CMD_BITS-2:0], 1'b0};
          if (cnt == CW'(CMD_BITS - 1)) begin
            state <= SMP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SMP: begin
          if (cnt == CW'(SMP_BITS - 1)) begin
            state <= READ;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        READ: begin
          sh <= {sh[DATA_BITS-3:0], dout};
          if (cnt == CW'(DATA_BITS - 1)) begin
            // newest channel enters at the top, so ch0 ends lowest
            res   <= {sh, dout, res[PACK_W-1:DATA_BITS]};
            state <= GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt <= '0;
            if (ch == 3'(NUM_CH - 1)) begin
              state <= DONE;
            end else begin
              state  <= CMD;
              ch     <= ch + 3'd1;
              cmd_sr <= {1'b1, SINGLE_ENDED, ch + 3'd1};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          dout_reg <= {{(RESULT_W - PACK_W){1'b0}}, res};
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // falling-edge retiming keeps pins stable across the ADC's rising latch
  always_ff @(negedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n <= 1'b1;
      din  <= 1'b0;
    end else begin
      cs_n <= !(state inside {CMD, SMP, READ});
      din  <= (state == CMD) & cmd_sr[CMD_BITS-1];
    end
  end

endmodule

// File: tb/tb_mcp3008_spi_interface.sv
// Randomized bench: behavioural MCP3008 model decodes the
// command bits and serves per-channel data; results are scored.
module tb_mcp3008_spi_interface;

  logic        dclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample = 1'b0;
  logic        dout = 1'b0;
  logic        din;
  logic        cs_n;
  logic        busy;
  logic [31:0] dout_reg;

  mcp3008_spi_interface #(
    .GAP_CYCLES   (2),
    .SINGLE_ENDED (1'b1)
  ) dut (
    .dclk     (dclk),
    .rst_n    (rst_n),
    .sample   (sample),
    .dout     (dout),
    .din      (din),
    .cs_n     (cs_n),
    .busy     (busy),
    .dout_reg (dout_reg)
  );

  always #5 dclk = ~dclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC model state
  int          k = 0;
  logic [4:0]  cmd_sh = '0;
  logic [2:0]  chan = '0;
  bit          tie_high = 1'b0;
  logic [9:0]  adc_val [8];
  logic [9:0]  cur_v;
  int          busy_cycles = 0;
  int          din_bad = 0;
  int          len_q[$];
  logic [4:0]  cmd_q[$];

  initial for (int i = 0; i < 8; i++) adc_val[i] = '0;

  always @(posedge dclk) begin
    if (busy) busy_cycles++;
    if (!cs_n) begin
      k++;
      if (k <= 5) begin
        cmd_sh = {cmd_sh[3:0], din};
        if (k == 5) begin
          cmd_q.push_back(cmd_sh);
          chan = cmd_sh[2:0];
        end
      end else if (din) begin
        din_bad++;
      end
    end else begin
      if (k != 0) len_q.push_back(k);
      k = 0;
      if (din) din_bad++;
    end
  end

  // B9..B0 shifted out on falling edges after the 7th latched clock
  always @(negedge dclk) begin
    cur_v = adc_val[chan];
    if (tie_high) dout = 1'b1;
    else if (k >= 7 && k <= 16) dout = cur_v[16-k];
    else dout = 1'b0;
  end

  task automatic pulse_sample();
    @(negedge dclk);
    sample = 1'b1;
    fork
      begin #10 sample = 1'b0; end
    join_none
  endtask

  task automatic run_round(input logic [9:0] a0,
                           input logic [9:0] a1,
                           input logic [9:0] a2,
                           input bit tie,
                           input bit repulse,
                           input string tag);
    logic [31:0] exp;
    int n;
    adc_val[0] = a0;
    adc_val[1] = a1;
    adc_val[2] = a2;
    tie_high = tie;
    if (tie) exp = (32'd1 << 30) - 32'd1;
    else exp = 32'(a0) + (32'(a1) << 10) + (32'(a2) << 20);
    len_q.delete();
    cmd_q.delete();
    busy_cycles = 0;
    din_bad = 0;
    pulse_sample();
    n = 0;
    while (!busy && n < 10) begin
      @(posedge dclk); #1;
      n++;
    end
    check({tag, ":latency"}, n, 3);
    if (repulse) begin
      repeat (20) @(posedge dclk);
      #2 sample = 1'b1;
      #10 sample = 1'b0;
    end
    n = 0;
    while (busy && n < 200) begin
      @(posedge dclk); #1;
      n++;
    end
    check({tag, ":busy_fall"}, busy, 0);
    repeat (4) @(posedge dclk);
    #1;
    check({tag, ":busy_cycles"}, busy_cycles, 58);
    check({tag, ":windows"}, len_q.size(), 3);
    foreach (len_q[i])
      check({tag, ":win_len"}, len_q[i], 17);
    foreach (cmd_q[i])
      check({tag, ":cmd"}, cmd_q[i], {2'b11, 3'(i)});
    check({tag, ":din_idle"}, din_bad, 0);
    check({tag, ":dout_reg"}, dout_reg, exp);
    if (repulse) check({tag, ":no_requeue"}, busy, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge dclk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_din", din, 0);
    check("rst_busy", busy, 0);
    check("rst_dout_reg", dout_reg, 0);
    @(negedge dclk);
    rst_n = 1'b1;
    repeat (3) @(posedge dclk);

    run_round(10'h000, 10'h000, 10'h000, 1'b1, 1'b0, "tie1");
    run_round(10'h155, 10'h2AA, 10'h001, 1'b0, 1'b0, "pat");
    run_round(10'h3FF, 10'h000, 10'h000, 1'b0, 1'b0, "b2b");
    run_round(10'($urandom), 10'($urandom), 10'($urandom),
              1'b0, 1'b1, "repulse");

    // reset during channel 1 READ
    adc_val[0] = 10'($urandom);
    adc_val[1] = 10'($urandom);
    adc_val[2] = 10'($urandom);
    tie_high = 1'b0;
    pulse_sample();
    n = 0;
    while (!busy && n < 10) begin
      @(posedge dclk); #1;
      n++;
    end
    check("mid_rst:start", busy, 1);
    repeat (27) @(posedge dclk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst:cs_n", cs_n, 1);
    check("mid_rst:busy", busy, 0);
    repeat (2) @(negedge dclk);
    rst_n = 1'b1;
    repeat (3) @(posedge dclk);
    #1;
    check("mid_rst:dout_reg", dout_reg, 0);
    check("mid_rst:idle", busy, 0);

    for (int r = 0; r < 3; r++)
      run_round(10'($urandom), 10'($urandom), 10'($urandom),
                1'b0, 1'b0, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
